// File: rtl/timing_engine_responder_if.sv
// Timing-engine <-> radio responder bundle: enable/direction/isolate in, reset/settle/RX/TX out.
// master = timing engine side, slave = responder; pllLockDet only with TER_LOCK_MONITOR_EN.
interface timing_engine_responder_if;
    logic radioEnable;
    logic radioRxEn;
    logic isolate;
`ifdef TER_LOCK_MONITOR_EN
    logic pllLockDet;
`endif
    logic tArstFs;
    logic pllSettled;
    logic rxActive;
    logic txActive;

    modport master (
        output radioEnable,
        output radioRxEn,
        output isolate,
`ifdef TER_LOCK_MONITOR_EN
        output pllLockDet,
`endif
        input  tArstFs,
        input  pllSettled,
        input  rxActive,
        input  txActive
    );

    modport slave (
        input  radioEnable,
        input  radioRxEn,
        input  isolate,
`ifdef TER_LOCK_MONITOR_EN
        input  pllLockDet,
`endif
        output tArstFs,
        output pllSettled,
        output rxActive,
        output txActive
    );
endinterface

// File: rtl/timing_engine_responder.sv
// Radio responder: FS reset pulse, PLL settle wait, break-before-make RX/TX, isolation clamp.
// Ports: ck, arst (async active-low), bus (slave). Option macro: TER_LOCK_MONITOR_EN.
module timing_engine_responder #(
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 40
) (
    input logic                       ck,
    input logic                       arst,
    timing_engine_responder_if.slave  bus
);
    localparam int MAXC = (RST_CYCLES > SETTLE_CYCLES) ?
                          RST_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SET_SAT  = CW'(SETTLE_CYCLES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FSRST  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] READY  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          tarst_q;
    logic          pll_q;
    logic          rx_q;
    logic          tx_q;
    logic          pend;
    logic          lock_ok;

`ifdef TER_LOCK_MONITOR_EN
    assign lock_ok = bus.pllLockDet;
`else
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge ck or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            cnt     <= '0;
            tarst_q <= 1'b0;
            pll_q   <= 1'b0;
            rx_q    <= 1'b0;
            tx_q    <= 1'b0;
            pend    <= 1'b0;
        end else if (state != IDLE && !bus.radioEnable) begin
            state   <= IDLE;
            cnt     <= '0;
            tarst_q <= 1'b0;
            pll_q   <= 1'b0;
            rx_q    <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (bus.radioEnable) begin
                        state   <= FSRST;
                        cnt     <= '0;
                        tarst_q <= 1'b1;
                    end
                end
                (state == FSRST): begin
                    if (cnt == RST_LAST) begin
                        state   <= SETTLE;
                        cnt     <= '0;
                        tarst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                (state == SETTLE): begin
                    if (cnt >= SET_LAST && lock_ok) begin
                        state <= READY;
                        cnt   <= '0;
                        pll_q <= 1'b1;
                        pend  <= bus.radioRxEn;
                    end else if (cnt != SET_SAT) begin
                        // saturate while waiting on lock
                        cnt <= cnt + 1'b1;
                    end
                end
                (state == READY): begin
                    if (!lock_ok) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        pll_q <= 1'b0;
                        rx_q  <= 1'b0;
                        tx_q  <= 1'b0;
                    end else begin
                        // pend holds last sampled direction; an
                        // enable asserts only after one stable gap
                        pend <= bus.radioRxEn;
                        if ((rx_q && !bus.radioRxEn) ||
                            (tx_q &&  bus.radioRxEn)) begin
                            rx_q <= 1'b0;
                            tx_q <= 1'b0;
                        end else if (!rx_q && !tx_q &&
                                     bus.radioRxEn == pend) begin
                            rx_q <=  bus.radioRxEn;
                            tx_q <= !bus.radioRxEn;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.tArstFs    = tarst_q & ~bus.isolate;
    assign bus.pllSettled = pll_q   & ~bus.isolate;
    assign bus.rxActive   = rx_q    & ~bus.isolate;
    assign bus.txActive   = tx_q    & ~bus.isolate;
endmodule

// File: tb/tb_timing_engine_responder.sv
// Scoreboard bench for timing_engine_responder: directed test-plan steps plus random traffic.
// Expected outputs come from an event/timestamp model; monitor compares on falling edges.
module tb_timing_engine_responder;
    localparam int RSTC = 4;
    localparam int SETC = 40;

    logic ck   = 1'b0;
    logic arst = 1'b0;

    timing_engine_responder_if bus();

    timing_engine_responder #(
        .RST_CYCLES    (RSTC),
        .SETTLE_CYCLES (SETC)
    ) dut (
        .ck   (ck),
        .arst (arst),
        .bus  (bus)
    );

    always #5 ck = ~ck;

    logic [3:0] q[$];
    int total = 0;
    int pass  = 0;

    bit c_en   = 0;
    bit c_rx   = 0;
    bit c_iso  = 0;
    bit c_lock = 1;

    int now = 0;
    bit m_on, m_ready, m_rx, m_tx, m_prev;
    int m_settle_t;

    function automatic void model_reset();
        m_on = 0; m_ready = 0; m_rx = 0; m_tx = 0; m_prev = 0;
        m_settle_t = 0;
    endfunction

    function automatic void model_edge();
        bit lk;
`ifdef TER_LOCK_MONITOR_EN
        lk = c_lock;
`else
        lk = 1'b1;
`endif
        now++;
        if (!arst) begin
            model_reset();
        end else if (!m_on) begin
            if (c_en) begin
                m_on = 1; m_ready = 0; m_rx = 0; m_tx = 0;
                m_settle_t = now + RSTC;
            end
        end else if (!c_en) begin
            model_reset();
        end else if (m_ready) begin
            if (!lk) begin
                m_ready = 0; m_rx = 0; m_tx = 0;
                m_settle_t = now;
            end else begin
                if ((m_rx && !c_rx) || (m_tx && c_rx)) begin
                    m_rx = 0; m_tx = 0;
                end else if (!m_rx && !m_tx && c_rx == m_prev) begin
                    m_rx = c_rx; m_tx = !c_rx;
                end
                m_prev = c_rx;
            end
        end else if (now >= m_settle_t + SETC && lk) begin
            m_ready = 1;
            m_prev  = c_rx;
        end
    endfunction

    function automatic logic [3:0] model_out();
        logic [3:0] o;
        o = {m_on && now < m_settle_t, m_ready, m_rx, m_tx};
        return c_iso ? 4'b0000 : o;
    endfunction

    always @(negedge ck) begin
        logic [3:0] e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {bus.tArstFs, bus.pllSettled, bus.rxActive, bus.txActive};
            total++;
            if (a === e) pass++;
            else $display("FAIL outs t=%0d act(fs,pll,rx,tx)=%b exp=%b",
                          now, a, e);
        end
    end

    task automatic step(input bit en, input bit rx, input bit iso,
                        input bit lock, input bit rstn);
        @(posedge ck);
        model_edge();
        #1;
        c_en = en; c_rx = rx; c_iso = iso; c_lock = lock;
        bus.radioEnable = en;
        bus.radioRxEn   = rx;
        bus.isolate     = iso;
`ifdef TER_LOCK_MONITOR_EN
        bus.pllLockDet  = lock;
`endif
        if (rstn) begin
            arst = 1'b1;
        end else if (arst) begin
            #2;
            arst = 1'b0;
            model_reset();
        end
        q.push_back(model_out());
    endtask

    task automatic run(input int n, input bit en, input bit rx,
                       input bit iso, input bit lock, input bit rstn);
        for (int i = 0; i < n; i++) step(en, rx, iso, lock, rstn);
    endtask

    initial begin
        bit en, rx, iso, lk, rn;
        model_reset();
        bus.radioEnable = 0;
        bus.radioRxEn   = 0;
        bus.isolate     = 0;
`ifdef TER_LOCK_MONITOR_EN
        bus.pllLockDet  = 1;
`endif
        run(3, 0, 0, 0, 1, 0);
        run(2, 0, 0, 0, 1, 1);
        run(60, 1, 1, 0, 1, 1);
        run(5, 1, 0, 0, 1, 1);
        run(1, 1, 1, 0, 1, 1);
        run(1, 1, 0, 0, 1, 1);
        run(1, 1, 1, 0, 1, 1);
        run(5, 1, 1, 0, 1, 1);
        run(10, 1, 1, 1, 1, 1);
        run(5, 1, 1, 0, 1, 1);
        run(1, 0, 1, 0, 1, 1);
        run(25, 1, 1, 0, 1, 1);
        run(1, 0, 1, 0, 1, 1);
        run(50, 1, 0, 0, 1, 1);
        run(1, 0, 0, 0, 1, 1);
        run(2, 1, 1, 0, 1, 1);
        run(3, 1, 1, 0, 1, 0);
        run(3, 0, 1, 0, 1, 1);
        run(50, 1, 1, 0, 1, 1);
`ifdef TER_LOCK_MONITOR_EN
        run(1, 1, 1, 0, 0, 1);
        run(45, 1, 1, 0, 1, 1);
        run(1, 0, 1, 0, 1, 1);
        run(60, 1, 1, 0, 0, 1);
        run(5, 1, 1, 0, 1, 1);
`endif
        en = 1; rx = 1; iso = 0; lk = 1; rn = 1;
        for (int i = 0; i < 4000; i++) begin
            en  = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 9) == 0) rx = !rx;
            iso = ($urandom_range(0, 29) == 0);
            lk  = ($urandom_range(0, 59) != 0);
            rn  = ($urandom_range(0, 499) != 0);
            step(en, rx, iso, lk, rn);
        end
        @(posedge ck);
        @(posedge ck);
        total++;
        if (q.size() == 0) pass++;
        else $display("FAIL drain left=%0d req=0", q.size());
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
